// File: rtl/dictionary_encoder_bank.sv
`default_nettype none
// ============================================================================
// Module   : dictionary_encoder_bank
// Purpose  : Replaces each input value with a compact dictionary id, building
//            the dictionary on the fly, and flushes it in id order at batch end.
// Revision : 1.0
// ============================================================================
module dictionary_encoder_bank #(
    parameter int VALUE_WIDTH  = 32,
    parameter int ID_WIDTH     = 4,
    parameter int SERIAL_WIDTH = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [VALUE_WIDTH-1:0]  in_value,
    input  logic [SERIAL_WIDTH-1:0] in_serial,
    input  logic                    in_last,

    output logic                    out_id_valid,
    input  logic                    out_id_ready,
    output logic [ID_WIDTH-1:0]     out_id,
    output logic [SERIAL_WIDTH-1:0] out_id_serial,
    output logic                    out_id_last,
    output logic                    out_id_overflow,

    output logic                    out_dict_valid,
    input  logic                    out_dict_ready,
    output logic [VALUE_WIDTH-1:0]  out_dict_value,
    output logic                    out_dict_last,

    output logic [ID_WIDTH:0]       dict_count
);

    localparam int                DEPTH  = 1 << ID_WIDTH;
    localparam logic [ID_WIDTH:0] C_FULL = (ID_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {
        ST_ENCODE = 1'b0,
        ST_FLUSH  = 1'b1
    } state_t;

    state_t                  state_q,       state_d;
    logic [ID_WIDTH:0]       dict_count_q,  dict_count_d;
    logic [ID_WIDTH-1:0]     rd_ptr_q,      rd_ptr_d;
    logic [DEPTH-1:0]        entry_valid_q, entry_valid_d;
    logic [VALUE_WIDTH-1:0]  entry_q [DEPTH];
    logic [VALUE_WIDTH-1:0]  entry_d [DEPTH];

    logic                    id_valid_q,    id_valid_d;
    logic [ID_WIDTH-1:0]     id_q,          id_d;
    logic [SERIAL_WIDTH-1:0] id_serial_q,   id_serial_d;
    logic                    id_last_q,     id_last_d;
    logic                    id_ovf_q,      id_ovf_d;

    logic                    w_hit;
    logic [ID_WIDTH-1:0]     w_hit_idx;
    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_dict_last;
    logic                    w_dict_hs;

    // Parallel CAM compare; descending scan leaves the lowest matching index.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entry_valid_q[i] && (entry_q[i] == in_value)) begin
                w_hit     = 1'b1;
                w_hit_idx = ID_WIDTH'(i);
            end
        end
    end

    assign w_in_ready  = (state_q == ST_ENCODE) && (!id_valid_q || out_id_ready);
    assign w_accept    = in_valid && w_in_ready;
    assign w_dict_last = ({1'b0, rd_ptr_q} == (dict_count_q - 1'b1));
    assign w_dict_hs   = (state_q == ST_FLUSH) && out_dict_ready;

    always_comb begin
        state_d       = state_q;
        dict_count_d  = dict_count_q;
        rd_ptr_d      = rd_ptr_q;
        entry_valid_d = entry_valid_q;
        entry_d       = entry_q;
        id_valid_d    = id_valid_q;
        id_d          = id_q;
        id_serial_d   = id_serial_q;
        id_last_d     = id_last_q;
        id_ovf_d      = id_ovf_q;

        // Output register drains independently of the dictionary stream.
        if (id_valid_q && out_id_ready) begin
            id_valid_d = 1'b0;
        end

        if (w_accept) begin
            id_valid_d  = 1'b1;
            id_serial_d = in_serial;
            id_last_d   = in_last;
            id_ovf_d    = 1'b0;
            if (w_hit) begin
                id_d = w_hit_idx;
            end else if (dict_count_q != C_FULL) begin
                id_d                                    = dict_count_q[ID_WIDTH-1:0];
                entry_d[dict_count_q[ID_WIDTH-1:0]]       = in_value;
                entry_valid_d[dict_count_q[ID_WIDTH-1:0]] = 1'b1;
                dict_count_d                            = dict_count_q + 1'b1;
            end else begin
                id_d     = '0;
                id_ovf_d = 1'b1;
            end
            if (in_last) begin
                state_d = ST_FLUSH;
            end
        end

        if (w_dict_hs) begin
            if (w_dict_last) begin
                rd_ptr_d      = '0;
                dict_count_d  = '0;
                entry_valid_d = '0;
                state_d       = ST_ENCODE;
            end else begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_ENCODE;
            dict_count_q  <= '0;
            rd_ptr_q      <= '0;
            entry_valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            id_valid_q    <= 1'b0;
            id_q          <= '0;
            id_serial_q   <= '0;
            id_last_q     <= 1'b0;
            id_ovf_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            dict_count_q  <= dict_count_d;
            rd_ptr_q      <= rd_ptr_d;
            entry_valid_q <= entry_valid_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
            id_valid_q    <= id_valid_d;
            id_q          <= id_d;
            id_serial_q   <= id_serial_d;
            id_last_q     <= id_last_d;
            id_ovf_q      <= id_ovf_d;
        end
    end

    assign in_ready        = w_in_ready;
    assign out_id_valid    = id_valid_q;
    assign out_id          = id_q;
    assign out_id_serial   = id_serial_q;
    assign out_id_last     = id_last_q;
    assign out_id_overflow = id_ovf_q;
    assign out_dict_valid  = (state_q == ST_FLUSH);
    assign out_dict_value  = entry_q[rd_ptr_q];
    assign out_dict_last   = (state_q == ST_FLUSH) && w_dict_last;
    assign dict_count      = dict_count_q;

endmodule
`default_nettype wire

// File: tb/tb_dictionary_encoder_bank.sv
`default_nettype none
// ============================================================================
// Module   : tb_dictionary_encoder_bank
// Purpose  : Directed self-checking bench for dictionary_encoder_bank
//            (default 16-entry instance plus a 4-entry instance for overflow).
// Revision : 1.0
// ============================================================================
module tb_dictionary_encoder_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // Instance A: ID_WIDTH = 4
    logic        in_valid, in_ready, in_last;
    logic [31:0] in_value;
    logic [15:0] in_serial;
    logic        out_id_valid, out_id_ready, out_id_last, out_id_overflow;
    logic [3:0]  out_id;
    logic [15:0] out_id_serial;
    logic        out_dict_valid, out_dict_ready, out_dict_last;
    logic [31:0] out_dict_value;
    logic [4:0]  dict_count;

    // Instance B: ID_WIDTH = 2
    logic        b_in_valid, b_in_ready, b_in_last;
    logic [31:0] b_in_value;
    logic [15:0] b_in_serial;
    logic        b_out_id_valid, b_out_id_ready, b_out_id_last, b_out_id_overflow;
    logic [1:0]  b_out_id;
    logic [15:0] b_out_id_serial;
    logic        b_out_dict_valid, b_out_dict_ready, b_out_dict_last;
    logic [31:0] b_out_dict_value;
    logic [2:0]  b_dict_count;

    dictionary_encoder_bank #(.VALUE_WIDTH(32), .ID_WIDTH(4), .SERIAL_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
        .in_serial(in_serial), .in_last(in_last),
        .out_id_valid(out_id_valid), .out_id_ready(out_id_ready), .out_id(out_id),
        .out_id_serial(out_id_serial), .out_id_last(out_id_last),
        .out_id_overflow(out_id_overflow),
        .out_dict_valid(out_dict_valid), .out_dict_ready(out_dict_ready),
        .out_dict_value(out_dict_value), .out_dict_last(out_dict_last),
        .dict_count(dict_count)
    );

    dictionary_encoder_bank #(.VALUE_WIDTH(32), .ID_WIDTH(2), .SERIAL_WIDTH(16)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_value(b_in_value),
        .in_serial(b_in_serial), .in_last(b_in_last),
        .out_id_valid(b_out_id_valid), .out_id_ready(b_out_id_ready), .out_id(b_out_id),
        .out_id_serial(b_out_id_serial), .out_id_last(b_out_id_last),
        .out_id_overflow(b_out_id_overflow),
        .out_dict_valid(b_out_dict_valid), .out_dict_ready(b_out_dict_ready),
        .out_dict_value(b_out_dict_value), .out_dict_last(b_out_dict_last),
        .dict_count(b_dict_count)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [15:0] serial;
        logic        last;
        logic        ovf;
    } id_rec_t;

    typedef struct packed {
        logic [31:0] value;
        logic        last;
    } dict_rec_t;

    id_rec_t   a_ids[$];
    id_rec_t   b_ids[$];
    dict_rec_t a_dict[$];
    dict_rec_t b_dict[$];

    int n_checks = 0;
    int n_errors = 0;

    // Handshakes are recorded half a cycle before the edge that completes them.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_id_valid && out_id_ready)
                a_ids.push_back('{out_id, out_id_serial, out_id_last, out_id_overflow});
            if (out_dict_valid && out_dict_ready)
                a_dict.push_back('{out_dict_value, out_dict_last});
            if (b_out_id_valid && b_out_id_ready)
                b_ids.push_back('{{2'b00, b_out_id}, b_out_id_serial, b_out_id_last, b_out_id_overflow});
            if (b_out_dict_valid && b_out_dict_ready)
                b_dict.push_back('{b_out_dict_value, b_out_dict_last});
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input bit sel, input logic [31:0] value, input logic [15:0] serial,
                        input logic last);
        int waited;
        logic rdy;
        waited = 0;
        if (sel) begin
            b_in_valid = 1'b1; b_in_value = value; b_in_serial = serial; b_in_last = last;
        end else begin
            in_valid = 1'b1; in_value = value; in_serial = serial; in_last = last;
        end
        forever begin
            @(negedge clk);
            rdy = sel ? b_in_ready : in_ready;
            if (rdy === 1'b1) break;
            waited++;
            if (waited > 50) begin
                chk("send_timeout", 64'(waited), 64'd0);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid   = 1'b0;
        b_in_valid = 1'b0;
    endtask

    task automatic expect_id(input bit sel, input logic [3:0] id, input logic [15:0] serial,
                             input logic last, input logic ovf);
        id_rec_t r;
        int      sz;
        sz = sel ? b_ids.size() : a_ids.size();
        chk("id_present", 64'(sz > 0), 64'd1);
        if (sz > 0) begin
            if (sel) r = b_ids.pop_front();
            else     r = a_ids.pop_front();
            chk("id", 64'(r.id), 64'(id));
            chk("id_serial", 64'(r.serial), 64'(serial));
            chk("id_last", 64'(r.last), 64'(last));
            chk("id_overflow", 64'(r.ovf), 64'(ovf));
        end
    endtask

    task automatic expect_dict(input bit sel, input logic [31:0] value, input logic last);
        dict_rec_t r;
        int        sz;
        sz = sel ? b_dict.size() : a_dict.size();
        chk("dict_present", 64'(sz > 0), 64'd1);
        if (sz > 0) begin
            if (sel) r = b_dict.pop_front();
            else     r = a_dict.pop_front();
            chk("dict_value", 64'(r.value), 64'(value));
            chk("dict_last", 64'(r.last), 64'(last));
        end
    endtask

    task automatic expect_empty(input bit sel);
        chk("id_extra", 64'(sel ? b_ids.size() : a_ids.size()), 64'd0);
        chk("dict_extra", 64'(sel ? b_dict.size() : a_dict.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] bvals [6];
        bit          hs_seen;
        bvals = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd1};

        rst_n = 1'b0;
        in_valid = 1'b0; in_value = '0; in_serial = '0; in_last = 1'b0;
        b_in_valid = 1'b0; b_in_value = '0; b_in_serial = '0; b_in_last = 1'b0;
        out_id_ready = 1'b1; out_dict_ready = 1'b1;
        b_out_id_ready = 1'b1; b_out_dict_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_id_valid", 64'(out_id_valid), 64'd0);
        chk("rst_dict_valid", 64'(out_dict_valid), 64'd0);
        chk("rst_overflow", 64'(out_id_overflow), 64'd0);
        chk("rst_id", 64'(out_id), 64'd0);
        chk("rst_id_serial", 64'(out_id_serial), 64'd0);
        chk("rst_id_last", 64'(out_id_last), 64'd0);
        chk("rst_dict_count", 64'(dict_count), 64'd0);
        chk("rst_b_id_valid", 64'(b_out_id_valid), 64'd0);
        chk("rst_b_dict_count", 64'(b_dict_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Mixed hits and misses
        send(0, 7, 0, 0); send(0, 9, 1, 0); send(0, 7, 2, 0); send(0, 9, 3, 0);
        send(0, 3, 4, 1);
        chk("t1_dict_count", 64'(dict_count), 64'd3);
        idle(8);
        expect_id(0, 0, 0, 0, 0); expect_id(0, 1, 1, 0, 0); expect_id(0, 0, 2, 0, 0);
        expect_id(0, 1, 3, 0, 0); expect_id(0, 2, 4, 1, 0);
        expect_dict(0, 7, 0); expect_dict(0, 9, 0); expect_dict(0, 3, 1);
        expect_empty(0);

        // Back-to-back duplicates
        send(0, 5, 0, 0); send(0, 5, 1, 0); send(0, 5, 2, 1);
        chk("t2_dict_count", 64'(dict_count), 64'd1);
        idle(6);
        expect_id(0, 0, 0, 0, 0); expect_id(0, 0, 1, 0, 0); expect_id(0, 0, 2, 1, 0);
        expect_dict(0, 5, 1);
        expect_empty(0);

        // Overflow on the 4-entry instance
        for (int i = 0; i < 6; i++) send(1, bvals[i], 16'(i), i == 5);
        chk("t3_b_dict_count", 64'(b_dict_count), 64'd4);
        idle(8);
        expect_id(1, 0, 0, 0, 0); expect_id(1, 1, 1, 0, 0); expect_id(1, 2, 2, 0, 0);
        expect_id(1, 3, 3, 0, 0); expect_id(1, 0, 4, 0, 1); expect_id(1, 0, 5, 1, 0);
        expect_dict(1, 1, 0); expect_dict(1, 2, 0); expect_dict(1, 3, 0); expect_dict(1, 4, 1);
        expect_empty(1);

        // Id backpressure, then dictionary backpressure toggling every cycle
        out_id_ready = 1'b0;
        send(0, 20, 0, 0);
        in_valid = 1'b1; in_value = 21; in_serial = 1; in_last = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            chk("bp_id_valid", 64'(out_id_valid), 64'd1);
            chk("bp_id_stable", 64'(out_id), 64'd0);
            chk("bp_serial_stable", 64'(out_id_serial), 64'd0);
        end
        @(posedge clk);
        #1;
        out_id_ready = 1'b1;
        send(0, 21, 1, 0);
        out_dict_ready = 1'b0;
        send(0, 22, 2, 1);
        repeat (10) begin
            @(posedge clk);
            #1;
            out_dict_ready = ~out_dict_ready;
        end
        out_dict_ready = 1'b1;
        idle(2);
        expect_id(0, 0, 0, 0, 0); expect_id(0, 1, 1, 0, 0); expect_id(0, 2, 2, 1, 0);
        expect_dict(0, 20, 0); expect_dict(0, 21, 0); expect_dict(0, 22, 1);
        expect_empty(0);

        // Two consecutive batches; input blocked until the final flush handshake
        send(0, 10, 0, 0);
        out_dict_ready = 1'b0;
        send(0, 11, 1, 1);
        in_valid = 1'b1; in_value = 11; in_serial = 2; in_last = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("flush_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk);
        #1;
        out_dict_ready = 1'b1;
        hs_seen = 1'b0;
        for (int c = 0; c < 10 && !hs_seen; c++) begin
            @(negedge clk);
            if (out_dict_valid && out_dict_last) begin
                chk("final_hs_in_ready", 64'(in_ready), 64'd0);
                hs_seen = 1'b1;
            end
        end
        chk("final_hs_seen", 64'(hs_seen), 64'd1);
        send(0, 11, 2, 0);
        send(0, 12, 3, 1);
        idle(6);
        expect_id(0, 0, 0, 0, 0); expect_id(0, 1, 1, 1, 0);
        expect_id(0, 0, 2, 0, 0); expect_id(0, 1, 3, 1, 0);
        expect_dict(0, 10, 0); expect_dict(0, 11, 1);
        expect_dict(0, 11, 0); expect_dict(0, 12, 1);
        expect_empty(0);

        // Reset mid-flush after the first of three entries, id beat still pending
        send(0, 30, 0, 0); send(0, 31, 1, 0);
        out_dict_ready = 1'b0;
        send(0, 32, 2, 1);
        out_id_ready = 1'b0;
        out_dict_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        out_dict_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_id_valid", 64'(out_id_valid), 64'd0);
        chk("mrst_dict_valid", 64'(out_dict_valid), 64'd0);
        chk("mrst_overflow", 64'(out_id_overflow), 64'd0);
        chk("mrst_id_serial", 64'(out_id_serial), 64'd0);
        chk("mrst_id_last", 64'(out_id_last), 64'd0);
        chk("mrst_dict_count", 64'(dict_count), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_id_ready = 1'b1;
        out_dict_ready = 1'b1;
        expect_id(0, 0, 0, 0, 0); expect_id(0, 1, 1, 0, 0);
        expect_dict(0, 30, 0);
        expect_empty(0);
        send(0, 8, 0, 1);
        idle(5);
        expect_id(0, 0, 0, 1, 0);
        expect_dict(0, 8, 1);
        expect_empty(0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dictionary_encoder_bank.md
Name: dictionary_encoder_bank

Overview:
- Encoder counterpart of the dictionary lookup bank: consumes a stream of values, builds a dictionary on the fly and replaces each value with a compact id.
- On the last input beat it streams the dictionary contents out in id order, so a downstream dictionary bank can be loaded and later decode the id stream.
- Uses a register-based CAM with parallel compare. Intended for small dictionaries, up to 64 entries.

Parameters:
- VALUE_WIDTH, 32, width of a dictionary value.
- ID_WIDTH, 4, id width; dictionary depth DEPTH = 2**ID_WIDTH.
- SERIAL_WIDTH, 16, width of the serial tag carried alongside each value.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; synchronous, active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- in_value  in  VALUE_WIDTH  value to encode.
- in_serial  in  SERIAL_WIDTH  serial tag, passed through unchanged.
- in_last  in  1  final beat of the current batch.
- out_id_valid  out  1  id beat valid.
- out_id_ready  in  1  id beat consumed.
- out_id  out  ID_WIDTH  assigned id.
- out_id_serial  out  SERIAL_WIDTH  tag of the originating input beat.
- out_id_last  out  1  copy of in_last.
- out_id_overflow  out  1  value could not be encoded (dictionary full); out_id is 0.
- out_dict_valid  out  1  dictionary beat valid.
- out_dict_ready  in  1  dictionary beat consumed.
- out_dict_value  out  VALUE_WIDTH  entry value; entry index equals its position in the flush.
- out_dict_last  out  1  final dictionary entry.
- dict_count  out  ID_WIDTH+1  number of occupied entries.

Behaviour:
- Reset values: state=ENCODE, dict_count=0, all entry-valid bits 0, rd_ptr=0.
- Reset values (outputs): out_id_valid=0, out_dict_valid=0, out_id_overflow=0, out_id/out_id_serial/out_id_last=0.
- Reset mid-batch discards all dictionary state and any pending output beat.
- State ENCODE:
  - in_ready = !out_id_valid || out_id_ready (single-entry output register, full throughput).
  - On accept, in_value is compared in parallel against entries 0..dict_count-1.
  - Hit: out_id = matching index.
  - Miss with dict_count < DEPTH: write entry[dict_count] = in_value; out_id = dict_count; dict_count increments.
  - Miss with dict_count == DEPTH: out_id = 0, out_id_overflow = 1, dictionary unchanged.
  - Latency: the id beat is registered and appears in the cycle after the accept.
  - out_id_serial and out_id_last are registered together with out_id.
  - Entries are registers. A value inserted in cycle N is visible to the compare in cycle N+1, so back-to-back duplicates both return the same id.
  - At most one entry can match; no priority logic is required beyond lowest index.
  - Accepting a beat with in_last=1 moves the state to FLUSH on the next cycle. dict_count >= 1 at that point.
- State FLUSH:
  - in_ready = 0.
  - out_dict_valid = 1; out_dict_value = entry[rd_ptr].
  - out_dict_last = (rd_ptr == dict_count-1).
  - On each dictionary handshake rd_ptr increments.
  - On the handshake with out_dict_last=1: rd_ptr=0, dict_count=0, entry-valid bits cleared, state=ENCODE.
  - The pending id beat (last of the batch) may still be held in the output register during FLUSH. It drains independently; id and dictionary streams have no mutual ordering.
- The output register holds its data stable while out_id_valid && !out_id_ready. This applies in both states.
- dict_count is never more than DEPTH; counter width is ID_WIDTH+1 so the full value DEPTH is representable.
- No input is accepted between the in_last accept and completion of the flush.

Test Plan:
- Values 7,9,7,9,3 with serials 0..4, last on serial 4, ready=1:
  - ids 0,1,0,1,2, serials 0..4, out_id_last only on beat 4.
  - Dictionary stream 7,9,3 with last on value 3.
- Back-to-back identical values 5,5,5 (last on third):
  - ids 0,0,0; dict_count ends at 1.
  - Flush emits the single value 5 with out_dict_last=1.
- ID_WIDTH=2, values 1,2,3,4,5,1 (last on the final 1):
  - ids 0,1,2,3; beat 5 gives id 0 with overflow=1; final beat gives id 0 with overflow=0.
  - Flush emits 1,2,3,4.
- Backpressure:
  - out_id_ready held 0 for 4 cycles after the first beat: in_ready=0 and out_id stable throughout; no beats lost or duplicated after release.
  - out_dict_ready toggling every cycle during flush: each entry emitted exactly once.
- Two consecutive batches:
  - Batch A: 10,11 (last). Batch B: 11,12 (last).
  - Batch B ids are 0,1, because the dictionary restarts at id 0; flush B emits 11,12.
  - in_ready stays 0 until batch A's final dictionary handshake.
- Reset asserted mid-flush after 1 of 3 entries:
  - all outputs return to their reset values the next cycle.
  - a new batch 8 (last) produces id 0 and dictionary beat 8 with last.
